// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared state type, latency limits and byte-lane merge for ram_sp_param
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 2;

    function automatic bit rd_latency_legal(input int lat);
        return (lat >= RD_LATENCY_MIN) && (lat <= RD_LATENCY_MAX);
    endfunction

    function automatic logic [7:0] merge_byte(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       en
    );
        return en ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// rtl/ram_rd_pipe.sv - LAT-stage shift of {valid, data} feeding the shared data bus
module ram_rd_pipe #(
    parameter int LAT = 1,
    parameter int W   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [LAT-1:0] vld;
    logic [W-1:0]   dat [LAT];

    // Only the valid bits are flushed; stale data behind a cleared valid is never driven.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld[0] <= in_valid;
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        dat[0] <= in_data;
        for (int i = 1; i < LAT; i++) begin
            dat[i] <= dat[i-1];
        end
    end

    assign out_valid = vld[LAT-1];
    assign out_data  = dat[LAT-1];

endmodule

// File: rtl/ram_sp_param.sv
// rtl/ram_sp_param.sv - parametrised single-port RAM on a shared bidirectional data bus
module ram_sp_param
    import ram_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int DEPTH      = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                read_en,
    input  logic                write_en,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W/8-1:0] be,
    input  logic                clear,
    inout  wire  [DATA_W-1:0]   data,
    output logic                rd_valid,
    output logic                busy,
    output logic                err
);

    localparam int                NB        = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    generate
        if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_latency
            $error("ram_sp_param: RD_LATENCY must be 1 or 2");
        end
        if ((DATA_W % 8) != 0) begin : g_bad_width
            $error("ram_sp_param: DATA_W must be a multiple of 8");
        end
    endgenerate

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data;
    logic              ready;
    logic              addr_ok;
    logic              req;
    logic              rd_acc;
    logic              wr_acc;

    assign ready   = (state == ST_READY);
    assign addr_ok = ({1'b0, addr} < DEPTH_LIM);
    assign req     = read_en | write_en;
    assign rd_acc  = ready && read_en && !write_en && addr_ok;
    // A write while read data is on the bus would fight the RAM's own driver.
    assign wr_acc  = ready && write_en && !read_en && addr_ok && !rd_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
            err     <= 1'b0;
        end else begin
            err <= req && !(rd_acc || wr_acc);
            case (state)
                ST_CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        state   <= ST_READY;
                        busy    <= 1'b0;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    if (clear) begin
                        state   <= ST_CLEAR;
                        busy    <= 1'b1;
                        clr_cnt <= '0;
                    end
                end
                default: begin
                    state   <= ST_CLEAR;
                    busy    <= 1'b1;
                    clr_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (wr_acc) begin
                for (int i = 0; i < NB; i++) begin
                    mem[addr][8*i +: 8] <= merge_byte(mem[addr][8*i +: 8], data[8*i +: 8], be[i]);
                end
            end
        end
    end

    ram_rd_pipe #(
        .LAT (RD_LATENCY),
        .W   (DATA_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_acc),
        .in_data   (mem[addr]),
        .out_valid (rd_valid),
        .out_data  (rd_data)
    );

    assign data = rd_valid ? rd_data : {DATA_W{1'bz}};

endmodule

// File: doc/ram_sp_param.md
# ram_sp_param

Parametrised single-port RAM with one bidirectional data bus. It adds the following to the fixed 16x8 single-port RAM:

- configurable width, depth and read latency
- byte-enabled writes
- a read-valid strobe that gates bus drive
- a hardware clear sequencer that zeroes memory after reset or on request
- an error strobe for illegal requests

It sits between a bus master and local storage wherever the team needs a shared inout data bus.

## Interface
Parameters:
- DATA_W, 8: data width; must be a multiple of 8.
- ADDR_W, 4: address width.
- DEPTH, 16: number of words; 1 ≤ DEPTH ≤ 2^ADDR_W.
- RD_LATENCY, 1: read latency in cycles; only 1 or 2 are legal.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- read_en  in  1  read request.
- write_en  in  1  write request.
- addr  in  ADDR_W  word address.
- be  in  DATA_W/8  byte enables for writes; bit i covers data[8i+7:8i].
- clear  in  1  one-cycle request to zero the whole memory.
- data  inout  DATA_W  master drives write data; RAM drives read data only while rd_valid=1, otherwise high-Z.
- rd_valid  out  1  read data is on data this cycle.
- busy  out  1  clear in progress; requests are not accepted.
- err  out  1  one-cycle pulse on a rejected request.

## Operation
- FSM states:
  - CLEAR: writes 0 to mem[clr_cnt], increments clr_cnt, and moves to READY after the clr_cnt=DEPTH-1 write.
  - READY: serves requests; clear=1 moves to CLEAR with clr_cnt=0.
- Reset values:
  - state=CLEAR, clr_cnt=0.
  - busy=1, rd_valid=0, err=0, data high-Z.
  - Read pipeline flushed.
- Accepted write: READY, write_en=1, read_en=0, addr<DEPTH, rd_valid=0.
  - mem[addr] byte i is updated from data when be[i]=1.
  - Bytes with be[i]=0 are unchanged.
- Accepted read: READY, read_en=1, write_en=0, addr<DEPTH.
  - mem[addr] is sampled at the acceptance edge and returned through the read pipeline.
- Rejected with err=1 for one cycle, with no memory change and no rd_valid:
  - read_en and write_en both high;
  - addr≥DEPTH;
  - any request while busy=1;
  - write_en while rd_valid=1, i.e. bus contention.
- clear and a request in the same READY cycle: the request executes, then CLEAR is entered.
- clear while in CLEAR is ignored.
- In-flight reads complete with their sampled data even if clear starts.
- rst mid-operation:
  - in-flight reads are dropped; rd_valid is never asserted for them;
  - the clear sequence restarts from address 0.

## Timing
- Read accepted at edge T: rd_valid=1 and data driven for the cycle after edge T+RD_LATENCY-1, i.e. RD_LATENCY cycles after the request cycle. Data is high-Z before and after.
- Back-to-back reads give one rd_valid per accepted read, in order. The pipeline accepts a read every cycle.
- Write visibility: a read accepted the cycle after a write returns the new data.
- Bus turnaround:
  - RD_LATENCY=1: a write is legal the cycle after rd_valid drops.
  - RD_LATENCY=2: a write in the cycle directly after a read is legal.
- Clear duration:
  - busy deasserts exactly DEPTH cycles after the first cycle with rst=0, or DEPTH cycles after the clear acceptance cycle.
  - First request is accepted in the cycle busy=0.
- err is registered and asserts the cycle after the offending request.

## Structure
- Shared package ram_pkg holds:
  - the state enumeration (CLEAR, READY);
  - the legal-RD_LATENCY check constant;
  - helper function for byte-lane merge.
- Sub-module ram_rd_pipe: RD_LATENCY-stage shift of {valid, data}, flushed by rst. Top-level drives data from its last stage.
- Memory array is inferred in the top level. The tristate assign is the only driver of data.

## Test plan
All scenarios use DATA_W=16, ADDR_W=4, DEPTH=12, RD_LATENCY=2.
- Reset and clear: rst high 2 cycles, then low.
  - busy=1 for exactly 12 cycles, then 0.
  - Reads of addresses 0..11 return 0x0000, each with rd_valid 2 cycles after request; data is Z otherwise.
- Full write and read-back: write 0xBEEF to addr 3 with be=2'b11; read addr 3.
  - Returns 0xBEEF with rd_valid 2 cycles later.
- Partial write: write 0x1234 to addr 3 with be=2'b01.
  - Read returns 0xBE34.
- Illegal requests, each giving an err pulse, no rd_valid and memory unchanged:
  - read_en=write_en=1 at addr 3;
  - read at addr 13;
  - write issued in a cycle with rd_valid=1.
- clear mid-stream: clear accepted while a read of addr 3 is in flight.
  - The read still returns 0xBE34.
  - busy=1 for 12 cycles.
  - Subsequent read of addr 3 returns 0x0000.
- Reset mid-read: rst asserted 1 cycle after a read is accepted.
  - rd_valid never asserts; data stays Z.
  - busy re-asserts, and the clear runs a full 12 cycles.
